// File: rtl/tcb_img_loader_if.sv
// Pixel-stream, network-handshake and host-result bundle for tcb_img_loader.
// The slave modport is the loader's view; master is the host/network view.
interface tcb_img_loader_if #(
  parameter int unsigned PIX_NUM = 121,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned OUT_W   = 32
);
  logic [PIX_W-1:0]         pix_in;
  logic                     pix_valid;
  logic                     pix_last;
  logic                     pix_ready;
  logic [PIX_NUM*PIX_W-1:0] img_out;
  logic                     valid_top;
  logic                     ready_top;
  logic [OUT_W-1:0]         number_in;
  logic [OUT_W-1:0]         result;
  logic                     result_valid;
  logic                     err_len;

  modport master (
    output pix_in, pix_valid, pix_last, ready_top, number_in,
    input  pix_ready, img_out, valid_top, result, result_valid, err_len
  );

  modport slave (
    input  pix_in, pix_valid, pix_last, ready_top, number_in,
    output pix_ready, img_out, valid_top, result, result_valid, err_len
  );
endinterface

// File: rtl/tcb_img_loader.sv
// Packs a serial pixel stream into the flat image bus, fires the TCB network and
// registers its prediction. Optional WAIT timeout enabled by TCB_LOADER_TIMEOUT_EN.
module tcb_img_loader #(
  parameter int unsigned PIX_NUM     = 121,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            rst,
  tcb_img_loader_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(PIX_NUM);
  localparam int unsigned IMG_W    = PIX_NUM * PIX_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_NUM - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               valid_top_q, valid_top_d;
  logic               result_valid_q, result_valid_d;
  logic               err_len_q, err_len_d;
  logic               beat_c;
  logic               timeout_c;

  assign bus.pix_ready    = rst && (state_q == ST_LOAD);
  assign beat_c           = bus.pix_valid && bus.pix_ready;
  assign bus.img_out      = img_q;
  assign bus.valid_top    = valid_top_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err_len      = err_len_q;

`ifdef TCB_LOADER_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // Counts WAIT cycles; zero whenever outside WAIT so entry always starts at 0.
  always_comb begin
    wcnt_d = '0;
    if (state_q == ST_WAIT) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign timeout_c = (state_q == ST_WAIT) && !bus.ready_top &&
                     (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (beat_c && (cnt_q == LAST_IDX)) state_d = ST_FIRE;
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: if (bus.ready_top || timeout_c) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Pulses are computed one cycle early so they line up with the state they announce.
  always_comb begin
    cnt_d          = cnt_q;
    img_d          = img_q;
    result_d       = result_q;
    valid_top_d    = 1'b0;
    result_valid_d = 1'b0;
    err_len_d      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (beat_c) begin
          for (int unsigned k = 0; k < PIX_NUM; k++) begin
            if (cnt_q == CNT_W'(k)) img_d[k*PIX_W +: PIX_W] = bus.pix_in;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d       = '0;
            valid_top_d = 1'b1;
            err_len_d   = !bus.pix_last;
          end else if (bus.pix_last) begin
            cnt_d     = '0;
            err_len_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (bus.ready_top) begin
          result_d       = bus.number_in;
          result_valid_d = 1'b1;
        end else if (timeout_c) begin
          result_d       = '1;
          result_valid_d = 1'b1;
          err_len_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      img_q          <= '0;
      result_q       <= '0;
      valid_top_q    <= 1'b0;
      result_valid_q <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      img_q          <= img_d;
      result_q       <= result_d;
      valid_top_q    <= valid_top_d;
      result_valid_q <= result_valid_d;
      err_len_q      <= err_len_d;
    end
  end

endmodule

// File: tb/tb_tcb_img_loader.sv
// Directed self-checking bench for tcb_img_loader: framing, handshake latency,
// mid-inference reset and (with TCB_LOADER_TIMEOUT_EN) the WAIT timeout.
module tb_tcb_img_loader;

  localparam int unsigned PIX_NUM = 121;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned OUT_W   = 32;
`ifdef TCB_LOADER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 16;
`else
  localparam int unsigned TIMEOUT_CYC = 4096;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   vt_cnt = 0;
  int   rv_cnt = 0;
  int   el_cnt = 0;
  int   vt0, rv0, el0;

  tcb_img_loader_if #(.PIX_NUM(PIX_NUM), .PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

  tcb_img_loader #(
    .PIX_NUM(PIX_NUM), .PIX_W(PIX_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.valid_top === 1'b1)    vt_cnt++;
    if (bus.result_valid === 1'b1) rv_cnt++;
    if (bus.err_len === 1'b1)      el_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int nbeats, input int last_idx, input int base);
    for (int k = 0; k < nbeats; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = PIX_W'(base + k);
      bus.pix_last  = (k == last_idx);
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic finish_inference(input logic [OUT_W-1:0] num);
    bus.number_in = num;
    bus.ready_top = 1'b1;
    tick();
    bus.ready_top = 1'b0;
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    bus.ready_top = 1'b0;
    bus.number_in = '0;
    tick();
    tick();
    check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("rst_valid_top", 64'(bus.valid_top), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_err_len", 64'(bus.err_len), 64'd0);
    check("rst_img", bus.img_out[63:0], 64'd0);
    rst = 1'b1;
    tick();
    check("idle_pix_ready", 64'(bus.pix_ready), 64'd1);

    // ready_top outside WAIT is ignored
    finish_inference(32'd9);
    tick();
    check("load_ready_ignored_rv", 64'(rv_cnt), 64'd0);
    check("load_ready_ignored_res", 64'(bus.result), 64'd0);

    // Full frame, values k
    send_frame(121, 120, 0);
    check("f1_valid_top", 64'(bus.valid_top), 64'd1);
    check("f1_pix_ready_fire", 64'(bus.pix_ready), 64'd0);
    check("f1_err_len", 64'(bus.err_len), 64'd0);
    check("f1_pix0", 64'(bus.img_out[7:0]), 64'h00);
    check("f1_pix1", 64'(bus.img_out[15:8]), 64'h01);
    check("f1_pix120", 64'(bus.img_out[967:960]), 64'h78);
    tick();
    check("f1_valid_top_1cyc", 64'(bus.valid_top), 64'd0);
    check("f1_pix_ready_wait", 64'(bus.pix_ready), 64'd0);
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'hAA;
    repeat (3) tick();
    bus.pix_valid = 1'b0;
    check("wait_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("wait_img_stable", 64'(bus.img_out[7:0]), 64'h00);
    finish_inference(32'd7);
    check("f1_result", 64'(bus.result), 64'd7);
    check("f1_result_valid", 64'(bus.result_valid), 64'd1);
    check("f1_pix_ready_back", 64'(bus.pix_ready), 64'd1);
    check("f1_no_err", 64'(bus.err_len), 64'd0);
    tick();
    check("f1_rv_1cyc", 64'(bus.result_valid), 64'd0);
    check("f1_result_hold", 64'(bus.result), 64'd7);
    check("f1_vt_count", 64'(vt_cnt), 64'd1);
    check("f1_rv_count", 64'(rv_cnt), 64'd1);

    // Early last on beat 50, then a good frame
    vt0 = vt_cnt;
    el0 = el_cnt;
    send_frame(51, 50, 8'h40);
    check("early_err_len", 64'(bus.err_len), 64'd1);
    check("early_no_vt", 64'(bus.valid_top), 64'd0);
    check("early_pix_ready", 64'(bus.pix_ready), 64'd1);
    tick();
    check("early_err_1cyc", 64'(bus.err_len), 64'd0);
    send_frame(121, 120, 3);
    check("f2_valid_top", 64'(bus.valid_top), 64'd1);
    check("f2_no_err", 64'(bus.err_len), 64'd0);
    check("f2_pix0", 64'(bus.img_out[7:0]), 64'h03);
    check("f2_pix50", 64'(bus.img_out[407:400]), 64'h35);
    check("f2_pix120", 64'(bus.img_out[967:960]), 64'h7B);
    tick();
    check("f2_vt_once", 64'(vt_cnt - vt0), 64'd1);
    check("f2_err_once", 64'(el_cnt - el0), 64'd1);
    finish_inference(32'h1234_5678);
    check("f2_result", 64'(bus.result), 64'h1234_5678);

    // Missing last: fires anyway with err_len alongside valid_top
    send_frame(121, -1, 8'h10);
    check("nolast_valid_top", 64'(bus.valid_top), 64'd1);
    check("nolast_err_len", 64'(bus.err_len), 64'd1);
    tick();
    check("nolast_err_1cyc", 64'(bus.err_len), 64'd0);
    finish_inference(32'd5);
    check("nolast_result", 64'(bus.result), 64'd5);
    tick();

    // Reset while in WAIT: pending result lost
    send_frame(121, 120, 8'h20);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_img", bus.img_out[63:0], 64'd0);
    rv0 = rv_cnt;
    bus.number_in = 32'h55;
    bus.ready_top = 1'b1;
    tick();
    tick();
    bus.ready_top = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_no_rv", 64'(rv_cnt - rv0), 64'd0);
    check("midrst_result_zero", 64'(bus.result), 64'd0);
    check("midrst_pix_ready_back", 64'(bus.pix_ready), 64'd1);
    send_frame(121, 120, 8'h30);
    check("f3_valid_top", 64'(bus.valid_top), 64'd1);
    tick();
    finish_inference(32'd3);
    check("f3_result", 64'(bus.result), 64'd3);
    check("f3_result_valid", 64'(bus.result_valid), 64'd1);
    tick();
    check("f3_rv_count", 64'(rv_cnt - rv0), 64'd1);

`ifdef TCB_LOADER_TIMEOUT_EN
    // Timeout after TIMEOUT_CYC WAIT cycles
    send_frame(121, 120, 0);
    rv0 = rv_cnt;
    repeat (16) tick();
    check("to_no_early_rv", 64'(rv_cnt - rv0), 64'd0);
    check("to_no_early_flag", 64'(bus.result_valid), 64'd0);
    tick();
    check("to_result_valid", 64'(bus.result_valid), 64'd1);
    check("to_err_len", 64'(bus.err_len), 64'd1);
    check("to_result", 64'(bus.result), 64'hFFFF_FFFF);
    check("to_pix_ready", 64'(bus.pix_ready), 64'd1);
    tick();
    // ready_top on the expiry cycle wins
    send_frame(121, 120, 0);
    repeat (16) tick();
    finish_inference(32'h11);
    check("to_ready_wins_result", 64'(bus.result), 64'h11);
    check("to_ready_wins_no_err", 64'(bus.err_len), 64'd0);
    check("to_ready_wins_rv", 64'(bus.result_valid), 64'd1);
    tick();
`else
    // Without the timeout, WAIT holds well past 16 cycles
    send_frame(121, 120, 0);
    rv0 = rv_cnt;
    repeat (40) tick();
    check("hold_no_rv", 64'(rv_cnt - rv0), 64'd0);
    check("hold_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("hold_result", 64'(bus.result), 64'd3);
    finish_inference(32'h11);
    check("hold_release_result", 64'(bus.result), 64'h11);
    check("hold_release_rv", 64'(bus.result_valid), 64'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcb_img_loader.md
Name: tcb_img_loader

Overview:
- Front-end stage that feeds the TCB network top (121x32x10 classifier) directly upstream.
- Accepts a serial 8-bit pixel stream under valid/ready and packs 121 pixels into the flat image bus.
- Issues a one-cycle start pulse to the network, waits for its done pulse, and registers the predicted class for the host.
- Refuses new pixels while an inference is in flight, so the image bus stays stable for the network.

Parameters:
- PIX_NUM, 121, pixels per image (11x11).
- PIX_W, 8, bits per pixel.
- OUT_W, 32, width of the prediction word.
- TIMEOUT_CYC, 4096, wait-state timeout in cycles; used only when TCB_LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pix_in  input  PIX_W  pixel data.
- pix_valid  input  1  pixel beat valid.
- pix_last  input  1  marks the final pixel of an image; sampled only on an accepted beat.
- pix_ready  output  1  loader can accept a beat.
- img_out  output  PIX_NUM*PIX_W  packed image to the network; pixel k occupies bits [k*PIX_W +: PIX_W], with pixel 0 at the LSBs.
- valid_top  output  1  one-cycle start pulse to the network.
- ready_top  input  1  one-cycle done pulse from the network; the prediction is valid in the same cycle.
- number_in  input  OUT_W  prediction from the network.
- result  output  OUT_W  registered prediction.
- result_valid  output  1  one-cycle pulse; result is updated in the same cycle.
- err_len  output  1  one-cycle framing-error pulse.

Behaviour:
- States: LOAD, FIRE, WAIT. Pixel counter cnt is ceil(log2(PIX_NUM)) bits wide.
- Reset (rst low, asynchronous):
  - state=LOAD, cnt=0, img_out=0, result=0.
  - valid_top=0, result_valid=0, err_len=0.
  - pix_ready is forced to 0 while rst is low.
- pix_ready=1 only in LOAD with rst high. A beat is accepted when pix_valid & pix_ready.
- LOAD:
  - On an accepted beat, write pix_in into slot cnt.
  - If cnt<PIX_NUM-1 and pix_last=0: cnt++.
  - If cnt<PIX_NUM-1 and pix_last=1 (early last): drop the frame, set cnt=0, pulse err_len next cycle, stay in LOAD. Stale img_out bits are allowed.
  - If cnt==PIX_NUM-1: set cnt=0 and go to FIRE. If pix_last=0 (missing last), still go to FIRE and pulse err_len next cycle.
- FIRE: valid_top=1 for exactly this one cycle; then go to WAIT.
- WAIT:
  - img_out is held stable; pix_ready=0.
  - On ready_top=1: result<=number_in, result_valid=1 next cycle, state goes to LOAD.
- ready_top in LOAD or FIRE is ignored; no result_valid is produced.
- Latency:
  - Final pixel accepted at edge T: valid_top is high in cycle T+1.
  - ready_top sampled at edge R: result_valid and pix_ready are both high in cycle R+1.
  - Minimum spacing between consecutive valid_top pulses is PIX_NUM+2 cycles.
- Reset mid-operation (any state): return immediately to reset values. A partial frame is discarded; a pending network result is lost.
- result holds its value until the next capture.
- valid_top, result_valid and err_len are registered, never combinational.

Optional Feature:
- Macro: TCB_LOADER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without ready_top: result<=all ones (32'hFFFF_FFFF), pulse result_valid and err_len in the same cycle, return to LOAD.
  - If ready_top arrives on the expiry cycle, ready_top wins: normal capture, no err_len.
- Not defined: no counter is instantiated; WAIT holds indefinitely until ready_top.

Test Plan:
- Reset then stream pixels 0..120 with values k[7:0], pix_last on beat 120 -> valid_top pulses one cycle after beat 120; img_out[7:0]=0x00, img_out[15:8]=0x01, img_out[967:960]=0x78; pix_ready=0 until done.
- In WAIT, drive ready_top=1 with number_in=7 -> next cycle result=7, result_valid=1 for one cycle, pix_ready=1.
- Assert pix_last on beat 50 -> err_len pulse, no valid_top; then a full 121-beat frame -> exactly one valid_top.
- Send 121 beats with pix_last never asserted -> valid_top fires and err_len pulses in the same cycle.
- Pull rst low while in WAIT, release, send a full frame and ready_top with number_in=3 -> result=3; no result_valid from the aborted inference.
- With TCB_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, never drive ready_top -> after 16 WAIT cycles, result=32'hFFFF_FFFF with result_valid and err_len pulsing together.
